// File: rtl/rmii_rx_pkg.sv
// Shared types and constants for the RMII receive deframer: FSM states,
// preamble/SFD dibits and the reflected CRC-32 constants plus its byte update.
package rmii_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_e;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  localparam logic [1:0] SFD_DIBIT = 2'b11;
  localparam logic [1:0] PRE_DIBIT = 2'b01;
  localparam logic [5:0] PRE_CNT_MAX = 6'd63;

  // Reflected CRC-32 advanced by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = {1'b0, c[31:1]} ^ CRC32_POLY;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide reflected CRC-32 update (poly 0xEDB88320).
module crc32_d8
  import rmii_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [31:0] crc_out
);

  assign crc_out = crc32_byte(crc_in, byte_in);

endmodule

// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: preamble/SFD lock, LSB-first byte assembly, length checks.
// Define RX_FCS_CHECK_EN to build the FCS checker; otherwise fcs_ok reads 1 at each frame end.
module rmii_rx_deframer
  import rmii_rx_pkg::*;
#(
  parameter int MIN_PRE_DIBITS = 20,
  parameter int MIN_BYTES      = 64,
  parameter int MAX_BYTES      = 1522
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crs_dv,
  input  logic [1:0] rxd,
  output logic [7:0] data_out,
  output logic       data_en,
  output logic       data_fin,
  output logic       fcs_ok,
  output logic       frm_err,
  output logic [10:0] byte_cnt
);

  localparam logic [5:0]  MIN_PRE = 6'(MIN_PRE_DIBITS);
  localparam logic [10:0] MIN_CNT = 11'(MIN_BYTES);
  localparam logic [10:0] MAX_CNT = 11'(MAX_BYTES);

  rx_state_e   state_r, next_state_s;
  logic [5:0]  pre_cnt_r;
  logic [1:0]  phase_r;
  logic [7:0]  sh_r;
  logic        oversize_r;
  logic [7:0]  data_out_r;
  logic        data_en_r, data_fin_r, fcs_ok_r, frm_err_r;
  logic [10:0] byte_cnt_r;

  logic [7:0]  byte_s;
  logic        sfd_s, shift_s, emit_s, ovf_s, fin_s, fcs_match_s;

  assign byte_s = {rxd, sh_r[7:2]};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (crs_dv && (rxd == PRE_DIBIT)) next_state_s = PRE;
        else                              next_state_s = IDLE;
      end
      PRE: begin
        if (!crs_dv)                                     next_state_s = IDLE;
        else if (rxd == PRE_DIBIT)                       next_state_s = PRE;
        else if ((rxd == SFD_DIBIT) && (pre_cnt_r >= MIN_PRE)) next_state_s = DATA;
        else                                             next_state_s = IDLE;
      end
      DATA: begin
        if (!crs_dv)    next_state_s = IDLE;
        else if (ovf_s) next_state_s = DROP;
        else            next_state_s = DATA;
      end
      DROP: begin
        if (!crs_dv) next_state_s = IDLE;
        else         next_state_s = DROP;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Per-cycle control strobes derived from state and pins
  always_comb begin
    sfd_s   = 1'b0;
    shift_s = 1'b0;
    emit_s  = 1'b0;
    ovf_s   = 1'b0;
    fin_s   = 1'b0;
    case (state_r)
      PRE: begin
        sfd_s = crs_dv && (rxd == SFD_DIBIT) && (pre_cnt_r >= MIN_PRE);
      end
      DATA: begin
        shift_s = crs_dv;
        emit_s  = crs_dv && (phase_r == 2'd3) && (byte_cnt_r != MAX_CNT);
        ovf_s   = crs_dv && (phase_r == 2'd3) && (byte_cnt_r == MAX_CNT);
        fin_s   = !crs_dv;
      end
      DROP: begin
        fin_s = !crs_dv;
      end
      default: begin
        sfd_s = 1'b0;
      end
    endcase
  end

  // Preamble run-length counter, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt_r <= 6'd0;
    end else if ((state_r == IDLE) && crs_dv && (rxd == PRE_DIBIT)) begin
      pre_cnt_r <= 6'd1;
    end else if ((state_r == PRE) && crs_dv && (rxd == PRE_DIBIT) && (pre_cnt_r != PRE_CNT_MAX)) begin
      pre_cnt_r <= pre_cnt_r + 6'd1;
    end else begin
      pre_cnt_r <= pre_cnt_r;
    end
  end

  // Byte assembly, strobes and end-of-frame status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_r       <= 8'h00;
      phase_r    <= 2'd0;
      oversize_r <= 1'b0;
      data_out_r <= 8'h00;
      data_en_r  <= 1'b0;
      data_fin_r <= 1'b0;
      fcs_ok_r   <= 1'b0;
      frm_err_r  <= 1'b0;
      byte_cnt_r <= 11'd0;
    end else begin
      data_en_r  <= emit_s;
      data_fin_r <= fin_s;
      if (emit_s) data_out_r <= byte_s;
      if (sfd_s) begin
        phase_r    <= 2'd0;
        oversize_r <= 1'b0;
        fcs_ok_r   <= 1'b0;
        frm_err_r  <= 1'b0;
        byte_cnt_r <= 11'd0;
      end else if (shift_s) begin
        sh_r    <= byte_s;
        phase_r <= phase_r + 2'd1;
        if (emit_s) byte_cnt_r <= byte_cnt_r + 11'd1;
        if (ovf_s)  oversize_r <= 1'b1;
      end else if (fin_s) begin
        frm_err_r <= (byte_cnt_r < MIN_CNT) || oversize_r || (phase_r != 2'd0);
        fcs_ok_r  <= fcs_match_s;
      end
    end
  end

`ifdef RX_FCS_CHECK_EN
  logic [31:0] crc_r, crc_next_s;

  crc32_d8 u_crc (
    .crc_in  (crc_r),
    .byte_in (byte_s),
    .crc_out (crc_next_s)
  );

  // Running CRC over every delivered byte, including the FCS itself
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_r <= CRC32_INIT;
    end else if (sfd_s) begin
      crc_r <= CRC32_INIT;
    end else if (emit_s) begin
      crc_r <= crc_next_s;
    end else begin
      crc_r <= crc_r;
    end
  end

  assign fcs_match_s = (crc_r == CRC32_RESIDUE);
`else
  assign fcs_match_s = 1'b1;
`endif

  assign data_out = data_out_r;
  assign data_en  = data_en_r;
  assign data_fin = data_fin_r;
  assign fcs_ok   = fcs_ok_r;
  assign frm_err  = frm_err_r;
  assign byte_cnt = byte_cnt_r;

endmodule
